serial_sign_applier: RTL and testbench

Bit-serial sign-magnitude to two's-complement converter. It is the return path for the `Absolute` block: a B-bit magnitude plus a sign bit go in, and the B-bit two's-complement value comes back out. The block processes one bit per clock, LSB first, using the copy-to-first-one-then-invert rule. It sits after magnitude-domain arithmetic and uses a ready/start/done handshake.

---
 rtl/serial_sign_applier_if.sv | 23 ++
 rtl/serial_sign_applier.sv | 121 ++++++++++++
 tb/tb_serial_sign_applier.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_sign_applier_if.sv
// Handshake and data bundle for the bit-serial sign applier.
// The requester drives start/sign/mag; the converter returns status and result.
interface serial_sign_applier_if #(
   parameter int B = 12
);
   logic         start;
   logic         sign;
   logic [B-1:0] mag;
   logic         ready;
   logic         done;
   logic [B-1:0] out;
   logic         range_err;

   modport master (
      output start, sign, mag,
      input  ready, done, out, range_err
   );

   modport slave (
      input  start, sign, mag,
      output ready, done, out, range_err
   );
endinterface

// File: rtl/serial_sign_applier.sv
// Bit-serial sign-magnitude to two's-complement converter.
// Walks the magnitude LSB first, copying bits up to and including the first
// one, then inverting the rest when the operand is negative.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; ready=1
// S_SHIFT | one magnitude bit converted per clock, B clocks in total
// S_DONE  | one-cycle done pulse; result already registered on out
module serial_sign_applier #(
   parameter int B = 12
) (
   input logic               clk,
   input logic               rst_n,
   serial_sign_applier_if.slave bus
);

   localparam int CW = $clog2(B);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [B-1:0]  HALF = {1'b1, {(B-1){1'b0}}};
   localparam logic [CW-1:0] LAST = CW'(B - 1);

   logic [1:0]    state_q,         state_d;
   logic [B-1:0]  shreg_q,         shreg_d;
   logic [B-1:0]  work_q,          work_d;
   logic [B-1:0]  out_q,           out_d;
   logic [CW-1:0] cnt_q,           cnt_d;
   logic          sign_q,          sign_d;
   logic          seen_one_q,      seen_one_d;
   logic          err_next_q,      err_next_d;
   logic          range_err_q,     range_err_d;

   logic          bit_in;
   logic          r_bit;

   // Next-state and datapath: load on accept, convert one bit per SHIFT cycle
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      work_d      = work_q;
      out_d       = out_q;
      cnt_d       = cnt_q;
      sign_d      = sign_q;
      seen_one_d  = seen_one_q;
      err_next_d  = err_next_q;
      range_err_d = range_err_q;

      bit_in = shreg_q[0];
      // Invert only once a one has already passed through; the first one
      // itself is copied unchanged.
      r_bit  = (sign_q && seen_one_q) ? ~bit_in : bit_in;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               shreg_d    = bus.mag;
               sign_d     = bus.sign;
               seen_one_d = 1'b0;
               cnt_d      = '0;
               // Positive values need MSB clear; negatives may reach -2^(B-1).
               err_next_d = (!bus.sign && bus.mag[B-1]) ||
                            (bus.sign && (bus.mag > HALF));
               state_d    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            seen_one_d = seen_one_q | bit_in;
            shreg_d    = {1'b0, shreg_q[B-1:1]};
            work_d     = {r_bit, work_q[B-1:1]};
            cnt_d      = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               out_d       = {r_bit, work_q[B-1:1]};
               range_err_d = err_next_q;
               cnt_d       = '0;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any conversion in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         work_q      <= '0;
         out_q       <= '0;
         cnt_q       <= '0;
         sign_q      <= 1'b0;
         seen_one_q  <= 1'b0;
         err_next_q  <= 1'b0;
         range_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         work_q      <= work_d;
         out_q       <= out_d;
         cnt_q       <= cnt_d;
         sign_q      <= sign_d;
         seen_one_q  <= seen_one_d;
         err_next_q  <= err_next_d;
         range_err_q <= range_err_d;
      end
   end

   assign bus.ready     = (state_q == S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.out       = out_q;
   assign bus.range_err = range_err_q;

endmodule

// File: tb/tb_serial_sign_applier.sv
// Directed bench for serial_sign_applier (B=12).
`timescale 1ns/1ps
module tb_serial_sign_applier;

   localparam int B = 12;

   logic clk;
   logic rst_n;

   int n_checks;
   int n_fail;

   serial_sign_applier_if #(.B(B)) bus ();

   serial_sign_applier #(.B(B)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          sign;
      logic [B-1:0]  mag;
      logic [B-1:0]  exp_out;
      logic          exp_err;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Entered and left at a negedge. Optionally pokes start during SHIFT.
   task automatic run_conv(input logic s, input logic [B-1:0] m,
                           input logic [B-1:0] eo, input logic ee,
                           input bit poke, input string name);
      logic [B-1:0] prev_out;
      int           n;
      n = 0;
      while (!bus.ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({name, " ready_before"}, {31'd0, bus.ready}, 32'd1);
      prev_out  = bus.out;
      bus.start = 1'b1;
      bus.sign  = s;
      bus.mag   = m;
      @(posedge clk);
      #1;
      check({name, " busy_after_accept"}, {31'd0, bus.ready}, 32'd0);
      bus.start = 1'b0;
      bus.sign  = ~s;
      bus.mag   = B'($urandom);
      for (int i = 1; i <= B; i++) begin
         @(negedge clk);
         if (poke) begin
            bus.start = i[0];
            bus.sign  = ~bus.sign;
            bus.mag   = B'($urandom);
         end
         check({name, " no_early_done"}, {31'd0, bus.done}, 32'd0);
         check({name, " out_held"}, {20'd0, bus.out}, {20'd0, prev_out});
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      check({name, " done"}, {31'd0, bus.done}, 32'd1);
      check({name, " out"}, {20'd0, bus.out}, {20'd0, eo});
      check({name, " range_err"}, {31'd0, bus.range_err}, {31'd0, ee});
      @(posedge clk);
      #1;
      check({name, " done_one_cycle"}, {31'd0, bus.done}, 32'd0);
      check({name, " ready_after"}, {31'd0, bus.ready}, 32'd1);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [B-1:0] alt_mag  [2];
      logic         alt_sign [2];
      logic [B-1:0] alt_exp  [2];
      int           acc_cnt, done_cnt, last_c;
      bit           prev_done, done_seen;

      n_checks = 0;
      n_fail   = 0;

      // sign, mag, expected out, expected range_err
      vecs[0]  = '{1'b0, 12'd1263, 12'h4EF, 1'b0};
      vecs[1]  = '{1'b1, 12'd83,   12'hFAD, 1'b0};
      vecs[2]  = '{1'b1, 12'd12,   12'hFF4, 1'b0};
      vecs[3]  = '{1'b1, 12'd0,    12'h000, 1'b0};
      vecs[4]  = '{1'b0, 12'd12,   12'h00C, 1'b0};
      vecs[5]  = '{1'b0, 12'd1263, 12'h4EF, 1'b0};
      vecs[6]  = '{1'b1, 12'd83,   12'hFAD, 1'b0};
      vecs[7]  = '{1'b1, 12'd12,   12'hFF4, 1'b0};
      vecs[8]  = '{1'b0, 12'd1201, 12'h4B1, 1'b0};
      vecs[9]  = '{1'b1, 12'd90,   12'hFA6, 1'b0};
      vecs[10] = '{1'b0, 12'd0,    12'h000, 1'b0};
      vecs[11] = '{1'b1, 12'd2048, 12'h800, 1'b0};
      vecs[12] = '{1'b0, 12'd2048, 12'h800, 1'b1};
      vecs[13] = '{1'b1, 12'd2049, 12'h7FF, 1'b1};
      vecs[14] = '{1'b0, 12'd5,    12'h005, 1'b0};
      vecs[15] = '{1'b0, 12'd2047, 12'h7FF, 1'b0};
      vecs[16] = '{1'b1, 12'd4095, 12'h001, 1'b1};

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.sign  = 1'b0;
      bus.mag   = '0;
      #22;
      check("reset ready", {31'd0, bus.ready}, 32'd1);
      check("reset done", {31'd0, bus.done}, 32'd0);
      check("reset out", {20'd0, bus.out}, 32'd0);
      check("reset range_err", {31'd0, bus.range_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 17; i++) begin
         run_conv(vecs[i].sign, vecs[i].mag, vecs[i].exp_out, vecs[i].exp_err,
                  1'b0, $sformatf("vec%0d", i));
      end

      // start pokes while busy must be ignored
      run_conv(1'b1, 12'd83, 12'hFAD, 1'b0, 1'b1, "poke");

      // start held high: accept every B+2 cycles, alternating operands
      alt_sign[0] = 1'b0; alt_mag[0] = 12'd100; alt_exp[0] = 12'h064;
      alt_sign[1] = 1'b1; alt_mag[1] = 12'd100; alt_exp[1] = 12'hF9C;
      acc_cnt   = 0;
      done_cnt  = 0;
      last_c    = 0;
      prev_done = 1'b0;
      bus.start = 1'b1;
      for (int c = 0; c < 100; c++) begin
         if (bus.done) begin
            check("stream done_width", {31'd0, prev_done}, 32'd0);
            check("stream out", {20'd0, bus.out}, {20'd0, alt_exp[done_cnt % 2]});
            done_cnt++;
            if (done_cnt == 4) begin
               bus.start = 1'b0;
               break;
            end
         end
         prev_done = bus.done;
         if (bus.ready) begin
            if (acc_cnt > 0) check("stream interval", c - last_c, 32'd14);
            last_c   = c;
            bus.sign = alt_sign[acc_cnt % 2];
            bus.mag  = alt_mag[acc_cnt % 2];
            acc_cnt++;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      check("stream completions", done_cnt, 32'd4);
      @(negedge clk);

      // asynchronous reset during SHIFT bit 5
      bus.start = 1'b1;
      bus.sign  = 1'b1;
      bus.mag   = 12'd300;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst out", {20'd0, bus.out}, 32'd0);
      check("midrst done", {31'd0, bus.done}, 32'd0);
      check("midrst ready", {31'd0, bus.ready}, 32'd1);
      check("midrst range_err", {31'd0, bus.range_err}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      done_seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.done) done_seen = 1'b1;
      end
      check("midrst no_done", {31'd0, done_seen}, 32'd0);
      run_conv(1'b1, 12'd300, 12'hED4, 1'b0, 1'b0, "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
